// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The sat signal exists only when CLA_PIPE_SAT_EN is defined.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef CLA_PIPE_SAT_EN
    logic             sat;
`endif
    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef CLA_PIPE_SAT_EN
        output sat,
`endif
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
`ifdef CLA_PIPE_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Operands are cut into BLOCK-bit lookahead groups; each of the STAGES register
// stages resolves an equal share of the groups and rippes the group carry on.
// Optional feature: define CLA_PIPE_SAT_EN to add signed saturation (bus.sat).
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NGRP = WIDTH / BLOCK;
    localparam int unsigned GPS  = NGRP / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    typedef logic [WIDTH-1:0] word_t;

    // Stage registers (index k = output of stage k)
    logic [STAGES-1:0] r_valid;
    word_t             r_a [STAGES];
    word_t             r_b [STAGES];   // already conditionally inverted
    word_t             r_s [STAGES];   // sum bits resolved so far
    logic [STAGES-1:0] r_c;            // carry into the next unresolved group
    logic [STAGES-1:0] r_cmsb;         // carry into the MSB
`ifdef CLA_PIPE_SAT_EN
    logic [STAGES-1:0] r_sat;
`endif

    // Stage inputs and combinational stage results
    word_t             w_a    [STAGES];
    word_t             w_b    [STAGES];
    word_t             w_s_in [STAGES];
    word_t             w_s    [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_cmsb_in;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_c;
    logic [STAGES-1:0] w_cmsb;
`ifdef CLA_PIPE_SAT_EN
    logic [STAGES-1:0] w_sat_in;
`endif
    logic [STAGES:0]   w_load;

    // One lookahead group: returns {group carry out, carry into group MSB, sum}.
    // Every carry is a two-level sum of products of g/p and the group carry in.
    function automatic logic [BLOCK+1:0] cla_group(input logic [BLOCK-1:0] ga,
                                                   input logic [BLOCK-1:0] gb,
                                                   input logic             gc);
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] c;
        logic             term;
        logic             gg;
        p = ga ^ gb;
        g = ga & gb;
        for (int i = 0; i < int'(BLOCK); i++) begin
            term = gc;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        gg = 1'b0;
        for (int j = 0; j < int'(BLOCK); j++) begin
            term = g[j];
            for (int m = j + 1; m < int'(BLOCK); m++) term = term & p[m];
            gg = gg | term;
        end
        return {gg | (&p & gc), c[BLOCK-1], p ^ c};
    endfunction

    // Select what each stage works on: fresh operands for stage 0, the previous
    // stage's registers otherwise.
    always_comb begin
        w_a[0]       = bus.a;
        w_b[0]       = bus.sub ? ~bus.b : bus.b;
        w_c_in[0]    = bus.sub | bus.cin;
        w_cmsb_in[0] = 1'b0;
        w_s_in[0]    = '0;
        w_vin[0]     = bus.in_valid;
`ifdef CLA_PIPE_SAT_EN
        w_sat_in[0]  = bus.sat;
`endif
        for (int k = 1; k < int'(STAGES); k++) begin
            w_a[k]       = r_a[k-1];
            w_b[k]       = r_b[k-1];
            w_c_in[k]    = r_c[k-1];
            w_cmsb_in[k] = r_cmsb[k-1];
            w_s_in[k]    = r_s[k-1];
            w_vin[k]     = r_valid[k-1];
`ifdef CLA_PIPE_SAT_EN
            w_sat_in[k]  = r_sat[k-1];
`endif
        end
    end

    // Resolve this stage's groups, rippling the group carry between them.
    always_comb begin
        logic             v_c;
        logic [BLOCK+1:0] v_grp;
        int unsigned      v_gi;
        v_c   = 1'b0;
        v_grp = '0;
        v_gi  = 0;
        for (int k = 0; k < int'(STAGES); k++) begin
            w_s[k]    = w_s_in[k];
            w_cmsb[k] = w_cmsb_in[k];
            v_c       = w_c_in[k];
            for (int q = 0; q < int'(GPS); q++) begin
                v_gi  = unsigned'(k) * GPS + unsigned'(q);
                v_grp = cla_group(w_a[k][v_gi*BLOCK +: BLOCK], w_b[k][v_gi*BLOCK +: BLOCK], v_c);
                w_s[k][v_gi*BLOCK +: BLOCK] = v_grp[BLOCK-1:0];
                if (v_gi == NGRP - 1) w_cmsb[k] = v_grp[BLOCK];
                v_c = v_grp[BLOCK+1];
            end
            w_c[k] = v_c;
        end
`ifdef CLA_PIPE_SAT_EN
        // On overflow the wrapped MSB is the inverse of the true sign.
        if (w_sat_in[LAST] && (w_c[LAST] ^ w_cmsb[LAST])) begin
            w_s[LAST] = w_s[LAST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                           : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Load enables: a stage loads when empty or when its successor loads.
    always_comb begin
        logic v_ld;
        v_ld           = bus.out_ready;
        w_load[STAGES] = v_ld;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            v_ld      = ~r_valid[k] | v_ld;
            w_load[k] = v_ld;
        end
    end

    // Stage registers; data only captured for valid beats so held outputs stay put.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(STAGES); k++) begin
            if (!rst_n) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_s[k]     <= '0;
                r_c[k]     <= 1'b0;
                r_cmsb[k]  <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                r_sat[k]   <= 1'b0;
`endif
            end else if (w_load[k]) begin
                r_valid[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_a[k]    <= w_a[k];
                    r_b[k]    <= w_b[k];
                    r_s[k]    <= w_s[k];
                    r_c[k]    <= w_c[k];
                    r_cmsb[k] <= w_cmsb[k];
`ifdef CLA_PIPE_SAT_EN
                    r_sat[k]  <= w_sat_in[k];
`endif
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[LAST];
    assign bus.s         = r_s[LAST];
    assign bus.cout      = r_c[LAST];
    assign bus.ovf       = r_c[LAST] ^ r_cmsb[LAST];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=32, BLOCK=4, STAGES=2).
// Saturation vectors are included when CLA_PIPE_SAT_EN is defined.
module tb_cla_pipe_adder;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_err    = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH (W),
        .BLOCK (4),
        .STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat on an idle pipeline: result must show after exactly two edges.
    task automatic do_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] es,
                           input logic ec, input logic eo);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_s"}, 64'(bus.s), 64'(es));
        check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
        tick();
        check({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Behavioural reference for the stream: {ovf, cout, s}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
        ov   = (a[31] == bb[31]) && (full[31] != a[31]);
        return {ov, full};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sa [8];
        logic [31:0] sb [8];
        logic [7:0]  ssub;
        logic [7:0]  scin;
        logic [33:0] expq [$];
        logic [33:0] e;
        logic [31:0] held_s;
        logic        held;
        logic        in_fire;
        logic        out_fire;
        int          sent;
        int          got;
        int          cyc;
        int          occ;

        // Reset held for two edges with in_valid asserted
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h1111_1111;
        bus.b         = 32'h2222_2222;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef CLA_PIPE_SAT_EN
        bus.sat       = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_s", 64'(bus.s), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_beat", 64'(bus.out_valid), 64'd0);
        end

        // Directed vectors
        do_beat("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_beat("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_beat("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_beat("add_cin", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
        do_beat("sub_cin_ign", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        do_beat("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_beat("add_neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`ifdef CLA_PIPE_SAT_EN
        bus.sat = 1'b1;
        do_beat("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        do_beat("sat_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        do_beat("sat_noovf", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        bus.sat = 1'b0;
`endif

        // Stream of 8 beats with out_ready pattern 1,0,0,1,0,0,...
        sa   = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hA5A5_A5A5};
        sb   = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                 32'h8765_4321, 32'h0000_0001, 32'h0000_0001, 32'h5A5A_5A5A};
        ssub = 8'b0110_1010;
        scin = 8'b1001_0100;
        sent = 0;
        got  = 0;
        cyc  = 0;
        occ  = 0;
        held = 1'b0;
        held_s = '0;
        while (got < 8 && cyc < 100) begin
            bus.out_ready = (cyc % 3 == 0);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.a   = sa[sent];
                bus.b   = sb[sent];
                bus.sub = ssub[sent];
                bus.cin = scin[sent];
            end
            #1;
            if (held) begin
                check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                check("bp_hold_s", 64'(bus.s), 64'(held_s));
            end
            check("bp_in_ready", 64'(bus.in_ready), 64'(!(occ == 2 && !bus.out_ready)));
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                if (expq.size() == 0) begin
                    check("bp_extra_beat", 64'd1, 64'(expq.size()));
                end else begin
                    e = expq.pop_front();
                    check("bp_s", 64'(bus.s), 64'(e[31:0]));
                    check("bp_cout", 64'(bus.cout), 64'(e[32]));
                    check("bp_ovf", 64'(bus.ovf), 64'(e[33]));
                    got++;
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_s = bus.s;
            if (in_fire) begin
                expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                sent++;
            end
            occ = occ + int'(in_fire) - int'(out_fire);
            tick();
            cyc++;
        end
        check("bp_count", 64'(got), 64'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_dup", 64'(bus.out_valid), 64'd0);
        end

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h0000_0010;
        bus.b         = 32'h0000_0020;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        tick();
        bus.a = 32'h0000_0030;
        tick();
        bus.in_valid = 1'b0;
        check("mid_full", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_beat", 64'(bus.out_valid), 64'd0);
        end
        do_beat("post_rst", 32'h0000_0100, 32'h0000_00FF, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into BLOCK-bit lookahead groups, and the group chain is divided across STAGES register stages. Operands enter and results leave through valid/ready handshakes. It is the wide, streaming successor of the fixed 8-bit CLA and sits in datapaths that need 16-64 bit add/sub at full clock rate.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of BLOCK
BLOCK, 4, bits per lookahead group; carry inside a group is full lookahead
STAGES, 2, pipeline register stages; must divide WIDTH/BLOCK; latency = STAGES cycles

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  1 = compute a-b (b inverted, carry-in forced 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Transfers occur on a rising clk edge when valid and ready are both high.
- Reset: rst_n=0 sampled at a clk edge clears every stage valid bit. This makes out_valid=0, s=0, cout=0 and ovf=0 in the next cycle. Reset in mid-operation discards all in-flight beats. in_ready=1 in the first cycle after reset. in_valid is ignored while rst_n=0.
- Per group: p=a^b', g=a&b' with b'=sub?~b:b. Group carry-out is the full lookahead form, as in the 4-bit CLA. Group generate/propagate feed a ripple of group carries inside a stage.
- Stage k (0..STAGES-1) resolves groups k*G/STAGES .. (k+1)*G/STAGES-1, where G=WIDTH/BLOCK. Each stage registers: remaining operand bits, finished sum bits, the carry between groups, the MSB carry-in, and valid.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, provided there is no backpressure. Throughput is 1 beat/cycle.
- Flow control per stage: stage i loads when its valid=0 or stage i+1 loads. The last stage's downstream load condition is out_ready. in_ready = stage0 load condition, which is combinational from out_ready through the chain.
- Bubbles collapse. A full pipeline with out_ready=0 holds every register unchanged and out_valid stays 1. No beat is dropped or duplicated.
- s, cout and ovf are stable while out_valid=1 and out_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry is reported only on cout.
- Simultaneous accept and emit on a full pipeline is legal and sustains 1 beat/cycle.

Optional Feature:
Macro CLA_PIPE_SAT_EN.
- Defined: adds input sat (1 bit, travels with the beat). When sat=1 and ovf=1, s is clamped to the signed limit: 0x7F..F if the true result is positive, 0x80..0 if negative. ovf is still reported. Clamping is done in the last stage, so latency is unchanged.
- Not defined: no sat port, and s is always the modular result.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, s=0, in_ready=1; no beat emerges after release.
- Add, WIDTH=32 STAGES=2: a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 2 cycles s=0x00000000, cout=1, ovf=0; the carry crosses the stage boundary.
- Subtract: a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Also a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, ovf=1.
- Backpressure: stream 8 random beats with out_ready toggled 1,0,0,1,... -> outputs match the reference model in order, with no loss or duplication; in_ready=0 exactly when full and out_ready=0.
- Reset mid-stream: 2 beats in flight, pulse rst_n=0 for one cycle -> neither beat is emitted; the next beat after reset has latency STAGES.
- CLA_PIPE_SAT_EN: a=0x7FFFFFFF, b=1, sat=1 -> s=0x7FFFFFFF, ovf=1. With sat=0 -> s=0x80000000, ovf=1.
